scan_mux: RTL and testbench
===========================

Name: scan_mux

Overview:
- Parametrised, registered N:1 multiplexer with a built-in channel scanner. It supersedes the purely combinational selector.
- Manual mode: output follows the external `sel`.
- Scan mode: an internal dwell counter steps through all non-masked channels automatically, replacing the testbench-driven `sel` sweep.
- Sits between multi-channel sources and a single-lane consumer (logger, serial link, display).

Parameters:
- sel_width, 3, select width; channel count N = 2**sel_width (min 1).
- data_width, 1, bits per channel (min 1).
- dwell, 32, clock cycles spent on each channel in scan mode (min 1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in  input  N*data_width  packed channels; channel k = in[k*data_width +: data_width]
- sel  input  sel_width  manual select; also the scan start channel
- mode  input  1  0 = manual, 1 = scan
- en  input  1  block enable
- skip_mask  input  N  bit k = 1 excludes channel k from scan (ignored in manual)
- out  output  data_width  registered selected data
- out_sel  output  sel_width  channel index that produced out
- out_valid  output  1  out/out_sel valid this cycle
- wrap  output  1  one-cycle pulse when the scan index wraps past channel N-1

Behaviour:
- Reset (rst_n low, async, dominates everything): out=0, out_sel=0, out_valid=0, wrap=0, ch=0, dwell count cnt=0, state=IDLE.
- cnt width = max(1, $clog2(dwell)).
- States: IDLE, MANUAL, SCAN. The state is re-evaluated every cycle from en/mode:
  - en=0 → IDLE
  - en=1, mode=0 → MANUAL
  - en=1, mode=1 → SCAN
- IDLE:
  - out and out_sel hold their last values.
  - out_valid=0, wrap=0, cnt frozen.
- MANUAL:
  - Each cycle: out <= channel[sel], out_sel <= sel, out_valid <= 1.
  - Latency is 1 clock from in/sel to out.
  - cnt is held at 0.
- Entry into SCAN (previous state ≠ SCAN):
  - ch <= first unmasked channel at or after sel, searching upward with modulo-N wrap. Search order is sel, sel+1, ..., N-1, 0, ..., sel-1.
  - cnt <= 0.
  - First valid output appears the cycle after entry.
- SCAN steady state:
  - Each cycle: out <= channel[ch] (live data, re-sampled every cycle), out_sel <= ch, out_valid <= 1.
  - When cnt == dwell-1: cnt <= 0 and ch <= next unmasked channel after ch (modulo N).
  - Otherwise cnt <= cnt+1.
  - With dwell=1, ch advances every cycle.
- wrap:
  - Asserted for exactly one cycle, coincident with the first out_valid of the new channel, when the advance moves ch to an index ≤ its previous value. Skipping over N-1 counts as a wrap.
  - Not asserted on scan entry.
  - With a single unmasked channel, wrap pulses at every dwell expiry.
- skip_mask changes mid-scan:
  - If the current ch becomes masked, advance to the next unmasked channel on the next cycle and reset cnt to 0. Wrap rule applies.
- All channels masked in SCAN:
  - out_valid=0, wrap=0, ch and out hold, cnt held at 0.
  - When any bit clears, behave as scan entry from the current ch.
- Mode switch mid-dwell:
  - SCAN→MANUAL takes effect the next cycle; cnt is discarded.
  - MANUAL→SCAN restarts from sel per the entry rule.
- en deassert mid-dwell then reassert with mode=1: treated as fresh entry (cnt=0, restart from sel).
- Reset asserted mid-scan: immediate async clear; after release the block starts in IDLE.
- Search for the next unmasked channel is combinational over N (priority rotate); no multi-cycle search.

Test Plan:
- Manual sweep: sel_width=3, data_width=1, en=1, mode=0, in incrementing each cycle, sel stepping 0..7 → out equals in[sel] from the previous cycle, out_sel=previous sel, out_valid=1, wrap never asserts.
- Scan, dwell=4, N=8, mask=0, sel=0, in=8'b10110010 static:
  - out_sel sequence 0×4, 1×4, ..., 7×4, then 0.
  - out = corresponding bit.
  - wrap high only on the first cycle of the second ch=0 period (cycle 33 after entry).
- Masked scan: dwell=2, skip_mask=8'b01011010, sel=3 →
  - ch order 5, 7, 0, 2, 5, ... (each 2 cycles).
  - wrap pulses on entering 0.
  - Set mask bit 7 while on 7 → next cycle ch=0, wrap=1.
- All masked: skip_mask=8'hFF during scan → out_valid=0 after one cycle, out/out_sel frozen. Clear bit 4 → ch=4 next, out_valid=1, no wrap.
- Mode/en transitions: scan at cnt=2 of dwell=4, switch mode=0 with sel=6 → next out_sel=6. Back to mode=1 → restart at 6 with full 4-cycle dwell. en=0 for 3 cycles → out_valid=0, out held.
- Reset mid-scan: pull rst_n low between clock edges → out, out_sel, out_valid and wrap go 0 immediately. After release with en=1, mode=1, sel=2 → first output ch=2.

Source files
------------

// File: rtl/scan_mux.sv
`timescale 1ns/1ps
// Registered N:1 mux with an automatic dwell-based scanner over non-masked channels.
// Latency 1 clk from in/sel to out; scan entry inserts one invalid cycle; no backpressure.
module scan_mux #(
  parameter int sel_width  = 3,
  parameter int data_width = 1,
  parameter int dwell      = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [(2**sel_width)*data_width-1:0]   in,
  input  logic [sel_width-1:0]                   sel,
  input  logic                                   mode,
  input  logic                                   en,
  input  logic [(2**sel_width)-1:0]              skip_mask,
  output logic [data_width-1:0]                  out,
  output logic [sel_width-1:0]                   out_sel,
  output logic                                   out_valid,
  output logic                                   wrap
);

  localparam int N  = 2**sel_width;
  localparam int CW = (dwell > 1) ? $clog2(dwell) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(dwell - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_e;

  // Priority rotate: first unmasked channel at or after start, wrapping modulo N.
  function automatic logic [sel_width-1:0] find_from(input logic [sel_width-1:0] start,
                                                     input logic [N-1:0]         mask);
    logic [sel_width-1:0] idx;
    logic                 found;
    find_from = start;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = start + i[sel_width-1:0];
      if (!found && !mask[idx]) begin
        find_from = idx;
        found     = 1'b1;
      end
    end
  endfunction

  state_e                state_q, state_d;
  logic [sel_width-1:0]  ch_q, ch_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [data_width-1:0] out_q, out_d;
  logic [sel_width-1:0]  out_sel_q, out_sel_d;
  logic                  out_valid_q, out_valid_d;
  logic                  wrap_q, wrap_d;
  logic                  wrap_pend_q, wrap_pend_d;
  logic                  blocked_q, blocked_d;

  logic                  all_masked;
  logic                  restart;
  logic [sel_width-1:0]  first_at_sel;
  logic [sel_width-1:0]  first_at_ch;
  logic [sel_width-1:0]  next_after_eff;
  logic [CW-1:0]         eff_cnt;
  logic                  eff_wrap;
  logic [data_width-1:0] sel_dat;
  logic [data_width-1:0] eff_dat;

  assign all_masked     = &skip_mask;
  assign first_at_sel   = find_from(sel, skip_mask);
  // Equals ch_q when ch_q is live, otherwise the channel the scan must jump to.
  assign first_at_ch    = find_from(ch_q, skip_mask);
  assign next_after_eff = find_from(first_at_ch + sel_width'(1), skip_mask);

  // Recovery from an all-masked stall or a freshly masked current channel restarts the dwell.
  assign restart  = blocked_q | skip_mask[ch_q];
  assign eff_cnt  = restart ? '0 : cnt_q;
  assign eff_wrap = blocked_q ? 1'b0
                  : (wrap_pend_q | (skip_mask[ch_q] & (first_at_ch <= ch_q)));

  assign sel_dat = in[int'(sel) * data_width +: data_width];
  assign eff_dat = in[int'(first_at_ch) * data_width +: data_width];

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = 1'b0;
    wrap_d      = 1'b0;
    wrap_pend_d = wrap_pend_q;
    blocked_d   = blocked_q;

    if (!en) begin
      state_d = IDLE;
    end else if (!mode) begin
      state_d     = MANUAL;
      out_d       = sel_dat;
      out_sel_d   = sel;
      out_valid_d = 1'b1;
      cnt_d       = '0;
      wrap_pend_d = 1'b0;
      blocked_d   = 1'b0;
    end else begin
      state_d = SCAN;
      if (state_q != SCAN) begin
        ch_d        = all_masked ? sel : first_at_sel;
        cnt_d       = '0;
        wrap_pend_d = 1'b0;
        blocked_d   = all_masked;
      end else if (all_masked) begin
        cnt_d       = '0;
        wrap_pend_d = 1'b0;
        blocked_d   = 1'b1;
      end else begin
        out_d       = eff_dat;
        out_sel_d   = first_at_ch;
        out_valid_d = 1'b1;
        wrap_d      = eff_wrap;
        blocked_d   = 1'b0;
        wrap_pend_d = 1'b0;
        ch_d        = first_at_ch;
        if (eff_cnt == CNT_LAST) begin
          cnt_d       = '0;
          ch_d        = next_after_eff;
          wrap_pend_d = (next_after_eff <= first_at_ch);
        end else begin
          cnt_d = eff_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      wrap_pend_q <= 1'b0;
      blocked_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      wrap_pend_q <= wrap_pend_d;
      blocked_q   <= blocked_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
`timescale 1ns/1ps
// Directed bench for scan_mux: manual table sweep plus scan, mask, mode and reset sequences.
module tb_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_v;
  logic [2:0] sel;
  logic       mode;
  logic       en;
  logic [7:0] mask;

  logic       u4_out, u2_out;
  logic [2:0] u4_sel, u2_sel;
  logic       u4_vld, u2_vld;
  logic       u4_wrap, u2_wrap;
  logic [5:0] o4, o2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scan_mux #(.sel_width(3), .data_width(1), .dwell(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in(in_v), .sel(sel), .mode(mode), .en(en),
    .skip_mask(mask), .out(u4_out), .out_sel(u4_sel), .out_valid(u4_vld), .wrap(u4_wrap)
  );

  scan_mux #(.sel_width(3), .data_width(1), .dwell(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in(in_v), .sel(sel), .mode(mode), .en(en),
    .skip_mask(mask), .out(u2_out), .out_sel(u2_sel), .out_valid(u2_vld), .wrap(u2_wrap)
  );

  assign o4 = {u4_out, u4_sel, u4_vld, u4_wrap};
  assign o2 = {u2_out, u2_sel, u2_vld, u2_wrap};

  typedef struct {
    logic [7:0] in;
    logic [2:0] sel;
    logic       en;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [5:0] ex(input logic o, input logic [2:0] s, input logic v, input logic w);
    return {o, s, v, w};
  endfunction

  function automatic vec_t mk(input logic [7:0] i, input logic [2:0] s, input logic e, input logic [5:0] x);
    vec_t r;
    r.in  = i;
    r.sel = s;
    r.en  = e;
    r.exp = x;
    return r;
  endfunction

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got out=%b sel=%0d vld=%b wrap=%b, expected out=%b sel=%0d vld=%b wrap=%b",
               name, got[5], got[4:2], got[1], got[0], exp[5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    int         mseq [11];
    int         s;

    // Manual sweep: out is in[sel] of the previous cycle; idle holds out/out_sel.
    tbl[0]  = mk(8'h5A, 3'd0, 1'b1, ex(1'b0, 3'd0, 1'b1, 1'b0));
    tbl[1]  = mk(8'h5B, 3'd1, 1'b1, ex(1'b1, 3'd1, 1'b1, 1'b0));
    tbl[2]  = mk(8'h5C, 3'd2, 1'b1, ex(1'b1, 3'd2, 1'b1, 1'b0));
    tbl[3]  = mk(8'h5D, 3'd3, 1'b1, ex(1'b1, 3'd3, 1'b1, 1'b0));
    tbl[4]  = mk(8'h5E, 3'd4, 1'b1, ex(1'b1, 3'd4, 1'b1, 1'b0));
    tbl[5]  = mk(8'h5F, 3'd5, 1'b1, ex(1'b0, 3'd5, 1'b1, 1'b0));
    tbl[6]  = mk(8'h60, 3'd6, 1'b1, ex(1'b1, 3'd6, 1'b1, 1'b0));
    tbl[7]  = mk(8'h61, 3'd7, 1'b1, ex(1'b0, 3'd7, 1'b1, 1'b0));
    tbl[8]  = mk(8'hFF, 3'd2, 1'b0, ex(1'b0, 3'd7, 1'b0, 1'b0));
    tbl[9]  = mk(8'h00, 3'd5, 1'b0, ex(1'b0, 3'd7, 1'b0, 1'b0));
    tbl[10] = mk(8'h80, 3'd7, 1'b1, ex(1'b1, 3'd7, 1'b1, 1'b0));
    tbl[11] = mk(8'h7F, 3'd7, 1'b1, ex(1'b0, 3'd7, 1'b1, 1'b0));

    pat     = 8'b1011_0010;
    mseq    = '{5, 5, 7, 7, 0, 0, 2, 2, 5, 5, 7};

    rst_n = 1'b0;
    in_v  = 8'h00;
    sel   = 3'd0;
    mode  = 1'b0;
    en    = 1'b0;
    mask  = 8'h00;

    #12;
    chk("reset_u4", o4, 6'b0);
    chk("reset_u2", o2, 6'b0);
    #5 rst_n = 1'b1;
    step();
    chk("post_reset_idle", o4, 6'b0);

    for (int i = 0; i < 12; i++) begin
      in_v = tbl[i].in;
      sel  = tbl[i].sel;
      en   = tbl[i].en;
      mode = 1'b0;
      mask = 8'h00;
      step();
      chk($sformatf("manual[%0d]", i), o4, tbl[i].exp);
    end

    // Full scan at dwell 4 from channel 0 with static data.
    in_v = pat;
    en   = 1'b0;
    step();
    sel  = 3'd0;
    mode = 1'b1;
    en   = 1'b1;
    step();
    chk("scan_entry", o4, ex(1'b0, 3'd7, 1'b0, 1'b0));
    for (int k = 1; k <= 36; k++) begin
      step();
      s = ((k - 1) / 4) % 8;
      chk($sformatf("scan[%0d]", k), o4, ex(pat[s], s[2:0], 1'b1, k == 33));
    end

    // Masked scan at dwell 2 starting from sel=3.
    en = 1'b0;
    step();
    mask = 8'b0101_1010;
    sel  = 3'd3;
    en   = 1'b1;
    step();
    chk("mask_entry", {4'b0, u2_vld, u2_wrap}, 6'b0);
    for (int i = 0; i < 11; i++) begin
      step();
      chk($sformatf("mask_seq[%0d]", i), o2, ex(pat[mseq[i]], mseq[i][2:0], 1'b1, i == 4));
    end
    mask = 8'b1101_1010;
    step();
    chk("mask_cur_jump", o2, ex(pat[0], 3'd0, 1'b1, 1'b1));
    step();
    chk("mask_cur_hold", o2, ex(pat[0], 3'd0, 1'b1, 1'b0));
    step();
    chk("mask_cur_next", o2, ex(pat[2], 3'd2, 1'b1, 1'b0));

    // All channels masked, then a single channel reopened.
    en   = 1'b0;
    mask = 8'h00;
    step();
    sel = 3'd1;
    en  = 1'b1;
    step();
    step();
    chk("allm_pre0", o4, ex(pat[1], 3'd1, 1'b1, 1'b0));
    step();
    chk("allm_pre1", o4, ex(pat[1], 3'd1, 1'b1, 1'b0));
    mask = 8'hFF;
    step();
    chk("allm_stall0", o4, ex(pat[1], 3'd1, 1'b0, 1'b0));
    step();
    chk("allm_stall1", o4, ex(pat[1], 3'd1, 1'b0, 1'b0));
    mask = 8'hEF;
    step();
    chk("allm_resume", o4, ex(pat[4], 3'd4, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("single_dwell[%0d]", i), o4, ex(pat[4], 3'd4, 1'b1, 1'b0));
    end
    step();
    chk("single_wrap", o4, ex(pat[4], 3'd4, 1'b1, 1'b1));

    // Mode and enable transitions mid-dwell.
    en   = 1'b0;
    mask = 8'h00;
    step();
    sel = 3'd0;
    en  = 1'b1;
    step();
    step();
    chk("mode_scan0", o4, ex(pat[0], 3'd0, 1'b1, 1'b0));
    step();
    chk("mode_scan1", o4, ex(pat[0], 3'd0, 1'b1, 1'b0));
    mode = 1'b0;
    sel  = 3'd6;
    step();
    chk("mode_to_manual", o4, ex(pat[6], 3'd6, 1'b1, 1'b0));
    mode = 1'b1;
    step();
    chk("mode_reentry", o4, ex(pat[6], 3'd6, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("mode_dwell6[%0d]", i), o4, ex(pat[6], 3'd6, 1'b1, 1'b0));
    end
    step();
    chk("mode_next7", o4, ex(pat[7], 3'd7, 1'b1, 1'b0));
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("en_off[%0d]", i), o4, ex(pat[7], 3'd7, 1'b0, 1'b0));
    end

    // Asynchronous reset in the middle of a scan.
    sel = 3'd5;
    en  = 1'b1;
    step();
    step();
    chk("rst_pre", o4, ex(pat[5], 3'd5, 1'b1, 1'b0));
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_u4", o4, 6'b0);
    chk("rst_async_u2", o2, 6'b0);
    #2;
    sel   = 3'd2;
    rst_n = 1'b1;
    step();
    chk("rst_reentry", o4, ex(1'b0, 3'd0, 1'b0, 1'b0));
    step();
    chk("rst_first", o4, ex(pat[2], 3'd2, 1'b1, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
